// File: rtl/enigma_pkg.sv
// Shared constants and types for the Enigma plugboard slice.
// Op encodings, default alphabet geometry, FSM state type.
package enigma_pkg;

    localparam int N_LETTERS_DEF = 26;
    localparam int IDX_W_DEF     = 5;
    localparam int MAX_PAIRS_DEF = 10;

    localparam logic [1:0] OP_ADD       = 2'd0;
    localparam logic [1:0] OP_REMOVE    = 2'd1;
    localparam logic [1:0] OP_CLEAR_ALL = 2'd2;
    localparam logic [1:0] OP_RSVD      = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_WRITE,
        S_DONE
    } cfg_state_e;

endpackage

// File: rtl/onehot_enc.sv
// One-hot letter to index encoder.
// bad_o flags zero or multiple bits set.
module onehot_enc
    import enigma_pkg::*;
#(
    parameter int N_LETTERS = N_LETTERS_DEF,
    parameter int IDX_W     = IDX_W_DEF
) (
    input  logic [N_LETTERS-1:0] onehot_i,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 bad_o
);

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N_LETTERS; i++) begin
            if (onehot_i[i]) begin
                idx_o = idx_o | IDX_W'(i);
            end
        end
        bad_o = !$onehot(onehot_i);
    end

endmodule

// File: rtl/plugboard_cfg.sv
// Plugboard: involutive letter map with a 2-stage lookup pipe
// and a handshake-driven configuration FSM.
module plugboard_cfg
    import enigma_pkg::*;
#(
    parameter int N_LETTERS = N_LETTERS_DEF,
    parameter int MAX_PAIRS = MAX_PAIRS_DEF,
    parameter int IDX_W     = IDX_W_DEF
) (
    input  logic                           CLOCK_50,
    input  logic                           reset,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic [1:0]                     cfg_op,
    input  logic [IDX_W-1:0]               cfg_a,
    input  logic [IDX_W-1:0]               cfg_b,
    output logic                           cfg_done,
    output logic                           cfg_err,
    output logic [$clog2(MAX_PAIRS+1)-1:0] pair_count,
    input  logic                           in_valid,
    input  logic [N_LETTERS-1:0]           in_letter,
    output logic                           out_valid,
    output logic [N_LETTERS-1:0]           out_letter,
    output logic                           out_err
);

    localparam int PC_W = $clog2(MAX_PAIRS + 1);
    localparam logic [IDX_W:0] NL = (IDX_W+1)'(N_LETTERS);
    localparam logic [PC_W-1:0] PC_MAX = PC_W'(MAX_PAIRS);

    logic [IDX_W-1:0] map_q [N_LETTERS];

    cfg_state_e       state_q;
    logic [1:0]       op_q;
    logic [IDX_W-1:0] a_q, b_q;
    logic [PC_W-1:0]  pc_q;
    logic             ready_q, done_q, err_q;

    logic             a_ok, b_ok, reject;
    logic [IDX_W-1:0] map_a, map_b;

    logic             s1_v_q, s1_bad_q;
    logic [IDX_W-1:0] s1_idx_q;
    logic             ov_q, oe_q;
    logic [N_LETTERS-1:0] ol_q, lut_d;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_bad;

    always_comb begin
        a_ok  = {1'b0, a_q} < NL;
        b_ok  = {1'b0, b_q} < NL;
        map_a = a_ok ? map_q[a_q] : a_q;
        map_b = b_ok ? map_q[b_q] : b_q;
        reject = 1'b1;
        unique case (op_q)
            OP_ADD: reject = !a_ok || !b_ok || (a_q == b_q) ||
                             (map_a != a_q) || (map_b != b_q) ||
                             (pc_q == PC_MAX);
            // a==b would otherwise match an unplugged letter and underflow the count
            OP_REMOVE: reject = !a_ok || !b_ok || (a_q == b_q) ||
                                (map_a != b_q);
            default: reject = 1'b1;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            pc_q    <= '0;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            for (int i = 0; i < N_LETTERS; i++) begin
                map_q[i] <= IDX_W'(i);
            end
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cfg_valid && ready_q) begin
                        op_q    <= cfg_op;
                        a_q     <= cfg_a;
                        b_q     <= cfg_b;
                        ready_q <= 1'b0;
                        state_q <= (cfg_op == OP_CLEAR_ALL) ? S_WRITE : S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (reject) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (op_q == OP_ADD) begin
                        map_q[a_q] <= b_q;
                        map_q[b_q] <= a_q;
                        pc_q       <= pc_q + PC_W'(1);
                    end else if (op_q == OP_REMOVE) begin
                        map_q[a_q] <= a_q;
                        map_q[b_q] <= b_q;
                        pc_q       <= pc_q - PC_W'(1);
                    end else begin
                        for (int i = 0; i < N_LETTERS; i++) begin
                            map_q[i] <= IDX_W'(i);
                        end
                        pc_q <= '0;
                    end
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    onehot_enc #(
        .N_LETTERS(N_LETTERS),
        .IDX_W    (IDX_W)
    ) u_enc (
        .onehot_i(in_letter),
        .idx_o   (enc_idx),
        .bad_o   (enc_bad)
    );

    // map_q is read before any same-cycle WRITE lands
    assign lut_d = N_LETTERS'(1) << map_q[s1_idx_q];

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            s1_v_q   <= 1'b0;
            s1_bad_q <= 1'b0;
            s1_idx_q <= '0;
            ov_q     <= 1'b0;
            oe_q     <= 1'b0;
            ol_q     <= '0;
        end else begin
            s1_v_q   <= in_valid;
            s1_bad_q <= enc_bad;
            s1_idx_q <= enc_idx;
            ov_q     <= s1_v_q;
            oe_q     <= s1_v_q && s1_bad_q;
            ol_q     <= (s1_v_q && !s1_bad_q) ? lut_d : '0;
        end
    end

    assign cfg_ready  = ready_q;
    assign cfg_done   = done_q;
    assign cfg_err    = err_q;
    assign pair_count = pc_q;
    assign out_valid  = ov_q;
    assign out_letter = ol_q;
    assign out_err    = oe_q;

endmodule

// File: tb/tb_plugboard_cfg.sv
// Directed self-checking bench for plugboard_cfg.
// Drives and samples 1 time unit after each rising edge.
module tb_plugboard_cfg;
    import enigma_pkg::*;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_op;
    logic [4:0]  cfg_a, cfg_b;
    logic        cfg_done, cfg_err;
    logic [3:0]  pair_count;
    logic        in_valid;
    logic [25:0] in_letter;
    logic        out_valid;
    logic [25:0] out_letter;
    logic        out_err;

    int passed = 0;
    int total  = 0;

    plugboard_cfg dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_op    (cfg_op),
        .cfg_a     (cfg_a),
        .cfg_b     (cfg_b),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .pair_count(pair_count),
        .in_valid  (in_valid),
        .in_letter (in_letter),
        .out_valid (out_valid),
        .out_letter(out_letter),
        .out_err   (out_err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic lookup(input logic [25:0] l, output logic v,
                          output logic [25:0] o, output logic e);
        in_letter = l;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        in_letter = '0;
        tick();
        v = out_valid;
        o = out_letter;
        e = out_err;
    endtask

    task automatic run_cfg(input logic [1:0] op, input logic [4:0] a,
                           input logic [4:0] b, output logic done,
                           output logic err);
        int n;
        n = 0;
        while (!cfg_ready && n < 20) begin
            tick();
            n++;
        end
        cfg_valid = 1'b1;
        cfg_op    = op;
        cfg_a     = a;
        cfg_b     = b;
        tick();
        cfg_valid = 1'b0;
        n = 0;
        while (!cfg_done && n < 20) begin
            tick();
            n++;
        end
        done = cfg_done;
        err  = cfg_err;
        if (done) tick();
    endtask

    task automatic test_reset();
        total++;
        if (out_valid !== 1'b0 || out_letter !== '0 || out_err !== 1'b0)
            $display("FAIL reset_out: v=%b l=%h e=%b want 0/0/0",
                     out_valid, out_letter, out_err);
        else passed++;
        total++;
        if (cfg_ready !== 1'b1 || cfg_done !== 1'b0 || cfg_err !== 1'b0)
            $display("FAIL reset_cfg: rdy=%b done=%b err=%b want 1/0/0",
                     cfg_ready, cfg_done, cfg_err);
        else passed++;
        total++;
        if (pair_count !== 4'd0)
            $display("FAIL reset_pc: got %0d want 0", pair_count);
        else passed++;
    endtask

    task automatic test_identity();
        logic v, e;
        logic [25:0] o;
        lookup(26'h2, v, o, e);
        total++;
        if (v !== 1'b1 || o !== 26'h2 || e !== 1'b0)
            $display("FAIL ident_B: v=%b l=%h e=%b want 1/0000002/0", v, o, e);
        else passed++;
    endtask

    task automatic test_add();
        logic d, er, v, e;
        logic [25:0] o;
        run_cfg(OP_ADD, 5'd1, 5'd5, d, er);
        total++;
        if (d !== 1'b1 || er !== 1'b0)
            $display("FAIL add_BF: done=%b err=%b want 1/0", d, er);
        else passed++;
        total++;
        if (cfg_done !== 1'b0 || cfg_err !== 1'b0)
            $display("FAIL done_pulse: done=%b err=%b want 0/0", cfg_done, cfg_err);
        else passed++;
        total++;
        if (pair_count !== 4'd1)
            $display("FAIL add_pc: got %0d want 1", pair_count);
        else passed++;
        lookup(26'h2, v, o, e);
        total++;
        if (v !== 1'b1 || o !== 26'h20 || e !== 1'b0)
            $display("FAIL sub_B: v=%b l=%h e=%b want 1/0000020/0", v, o, e);
        else passed++;
        lookup(26'h20, v, o, e);
        total++;
        if (o !== 26'h2)
            $display("FAIL sub_F: got %h want 0000002", o);
        else passed++;
    endtask

    task automatic test_reject();
        logic d, er, v, e;
        logic [25:0] o;
        run_cfg(OP_ADD, 5'd5, 5'd9, d, er);
        total++;
        if (d !== 1'b1 || er !== 1'b1 || pair_count !== 4'd1)
            $display("FAIL add_busy: done=%b err=%b pc=%0d want 1/1/1", d, er, pair_count);
        else passed++;
        lookup(26'h20, v, o, e);
        total++;
        if (o !== 26'h2)
            $display("FAIL busy_map: F->%h want 0000002", o);
        else passed++;
        lookup(26'h200, v, o, e);
        total++;
        if (o !== 26'h200)
            $display("FAIL busy_J: J->%h want 0000200", o);
        else passed++;
        run_cfg(OP_ADD, 5'd3, 5'd3, d, er);
        total++;
        if (d !== 1'b1 || er !== 1'b1)
            $display("FAIL add_self: done=%b err=%b want 1/1", d, er);
        else passed++;
        run_cfg(OP_REMOVE, 5'd1, 5'd6, d, er);
        total++;
        if (er !== 1'b1 || pair_count !== 4'd1)
            $display("FAIL rem_wrong: err=%b pc=%0d want 1/1", er, pair_count);
        else passed++;
        run_cfg(OP_RSVD, 5'd2, 5'd4, d, er);
        total++;
        if (d !== 1'b1 || er !== 1'b1)
            $display("FAIL op_rsvd: done=%b err=%b want 1/1", d, er);
        else passed++;
        run_cfg(OP_ADD, 5'd25, 5'd26, d, er);
        total++;
        if (er !== 1'b1 || pair_count !== 4'd1)
            $display("FAIL add_range: err=%b pc=%0d want 1/1", er, pair_count);
        else passed++;
    endtask

    task automatic test_remove();
        logic d, er, v, e;
        logic [25:0] o;
        run_cfg(OP_REMOVE, 5'd5, 5'd1, d, er);
        total++;
        if (d !== 1'b1 || er !== 1'b0 || pair_count !== 4'd0)
            $display("FAIL rem_FB: done=%b err=%b pc=%0d want 1/0/0", d, er, pair_count);
        else passed++;
        lookup(26'h2, v, o, e);
        total++;
        if (o !== 26'h2)
            $display("FAIL rem_map: B->%h want 0000002", o);
        else passed++;
        run_cfg(OP_REMOVE, 5'd1, 5'd5, d, er);
        total++;
        if (er !== 1'b1 || pair_count !== 4'd0)
            $display("FAIL rem_free: err=%b pc=%0d want 1/0", er, pair_count);
        else passed++;
        run_cfg(OP_ADD, 5'd1, 5'd5, d, er);
        total++;
        if (er !== 1'b0 || pair_count !== 4'd1)
            $display("FAIL readd: err=%b pc=%0d want 0/1", er, pair_count);
        else passed++;
    endtask

    task automatic test_full();
        logic d, er, v, e;
        logic [25:0] o, w;
        logic [4:0] pa [9] = '{5'd0, 5'd3, 5'd6, 5'd8, 5'd11, 5'd13, 5'd15, 5'd17, 5'd19};
        logic [4:0] pb [9] = '{5'd2, 5'd4, 5'd7, 5'd10, 5'd12, 5'd14, 5'd16, 5'd18, 5'd20};
        int bad;
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            run_cfg(OP_ADD, pa[i], pb[i], d, er);
            if (d !== 1'b1 || er !== 1'b0) bad++;
        end
        total++;
        if (bad != 0 || pair_count !== 4'd10)
            $display("FAIL fill: rejects=%0d pc=%0d want 0/10", bad, pair_count);
        else passed++;
        lookup(26'h1000, v, o, e);
        total++;
        if (o !== 26'h800)
            $display("FAIL full_M: M->%h want 0000800", o);
        else passed++;
        run_cfg(OP_ADD, 5'd21, 5'd22, d, er);
        total++;
        if (er !== 1'b1 || pair_count !== 4'd10)
            $display("FAIL add_full: err=%b pc=%0d want 1/10", er, pair_count);
        else passed++;
        run_cfg(OP_CLEAR_ALL, 5'd0, 5'd0, d, er);
        total++;
        if (d !== 1'b1 || er !== 1'b0 || pair_count !== 4'd0)
            $display("FAIL clear: done=%b err=%b pc=%0d want 1/0/0", d, er, pair_count);
        else passed++;
        for (int i = 0; i < 26; i++) begin
            w = 26'h1 << i;
            lookup(w, v, o, e);
            total++;
            if (v !== 1'b1 || o !== w || e !== 1'b0)
                $display("FAIL clear_id%0d: v=%b l=%h e=%b want 1/%h/0", i, v, o, e, w);
            else passed++;
        end
    endtask

    task automatic test_bad_onehot();
        logic v, e;
        logic [25:0] o;
        lookup(26'h2, v, o, e);
        lookup(26'h3, v, o, e);
        total++;
        if (v !== 1'b1 || o !== '0 || e !== 1'b1)
            $display("FAIL multi_hot: v=%b l=%h e=%b want 1/0/1", v, o, e);
        else passed++;
        lookup(26'h0, v, o, e);
        total++;
        if (v !== 1'b1 || o !== '0 || e !== 1'b1)
            $display("FAIL zero_hot: v=%b l=%h e=%b want 1/0/1", v, o, e);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0 || out_letter !== '0 || out_err !== 1'b0)
            $display("FAIL idle_out: v=%b l=%h e=%b want 0/0/0",
                     out_valid, out_letter, out_err);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic d, er;
        logic [25:0] w;
        int nv, bad;
        run_cfg(OP_ADD, 5'd0, 5'd25, d, er);
        total++;
        if (er !== 1'b0 || pair_count !== 4'd1)
            $display("FAIL add_AZ: err=%b pc=%0d want 0/1", er, pair_count);
        else passed++;
        nv = 0;
        bad = 0;
        for (int c = 0; c < 28; c++) begin
            if (c >= 2) begin
                if (c == 2) w = 26'h1 << 25;
                else if (c == 27) w = 26'h1;
                else w = 26'h1 << (c - 2);
                if (out_valid === 1'b1) nv++;
                if (out_letter !== w || out_err !== 1'b0) bad++;
            end
            if (c < 26) begin
                in_valid  = 1'b1;
                in_letter = 26'h1 << c;
            end else begin
                in_valid  = 1'b0;
                in_letter = '0;
            end
            tick();
        end
        total++;
        if (nv != 26 || bad != 0)
            $display("FAIL stream: valids=%0d wrong=%0d want 26/0", nv, bad);
        else passed++;
        total++;
        if (out_valid !== 1'b0)
            $display("FAIL stream_end: out_valid=%b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic v, e;
        logic [25:0] o;
        int nd;
        cfg_valid = 1'b1;
        cfg_op    = OP_ADD;
        cfg_a     = 5'd1;
        cfg_b     = 5'd5;
        tick();
        cfg_valid = 1'b0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (cfg_ready !== 1'b1)
            $display("FAIL rst_ready: got %b want 1", cfg_ready);
        else passed++;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            if (cfg_done === 1'b1) nd++;
            tick();
        end
        total++;
        if (nd != 0 || pair_count !== 4'd0)
            $display("FAIL rst_drop: done_pulses=%0d pc=%0d want 0/0", nd, pair_count);
        else passed++;
        lookup(26'h2, v, o, e);
        total++;
        if (o !== 26'h2)
            $display("FAIL rst_map: B->%h want 0000002", o);
        else passed++;
    endtask

    initial begin
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_op    = '0;
        cfg_a     = '0;
        cfg_b     = '0;
        in_valid  = 1'b1;
        in_letter = 26'h4;
        repeat (3) tick();
        in_valid  = 1'b0;
        in_letter = '0;
        test_reset();
        reset = 1'b0;
        tick();
        test_identity();
        test_add();
        test_reject();
        test_remove();
        test_full();
        test_bad_onehot();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
